// File: rtl/multi_tick_divider.sv
// Multi-channel programmable tick divider: per-channel one-cycle tick strobe and 50%-duty divided clock.
// Optional macro TICK_DIVIDER_SYNC_EN adds a sync_in port that phase-aligns every channel.
module multi_tick_divider #(
   parameter int          NUM_CH      = 4,
   parameter int          DIV_WIDTH   = 32,
   parameter int          CH_SEL_W    = 2,
   parameter int unsigned DEFAULT_DIV = 0
) (
   input  logic                 clk_src,
   input  logic                 rst,
   input  logic                 en,
`ifdef TICK_DIVIDER_SYNC_EN
   input  logic                 sync_in,
`endif
   input  logic                 cfg_we,
   input  logic [CH_SEL_W-1:0]  cfg_ch,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic [NUM_CH-1:0]    tick,
   output logic [NUM_CH-1:0]    clk_out
);

   localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

   logic sync_all;

`ifdef TICK_DIVIDER_SYNC_EN
   assign sync_all = sync_in;
`else
   assign sync_all = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_q, div_d;
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic                 tick_q, tick_d;
      logic                 clk_q, clk_d;
      logic                 wr_hit;
      logic                 run;
      logic                 terminal;

      // Only addresses that map to a real channel can match, so out-of-range writes fall through.
      assign wr_hit   = cfg_we && (cfg_ch == CH_SEL_W'(i));
      assign run      = en && (div_q != '0);
      assign terminal = (cnt_q == div_q - ONE);

      always_comb begin
         // NOTE: every output of this block gets a default first, so no path can infer a latch.
         div_d  = div_q;
         cnt_d  = cnt_q;
         tick_d = 1'b0;
         clk_d  = clk_q;
         if (sync_all) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (wr_hit) begin
               div_d = cfg_div;
            end
         end else if (wr_hit) begin
            // A write on the terminal edge wins: no tick, no toggle.
            div_d = cfg_div;
            cnt_d = '0;
         end else if (run) begin
            if (terminal) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               clk_d  = ~clk_q;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
      end

      always_ff @(posedge clk_src) begin
         // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
         if (rst) begin
            div_q  <= RESET_DIV;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
         end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
         end
      end

      assign tick[i]    = tick_q;
      assign clk_out[i] = clk_q;
   end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider: vector table, directed corner sequences and a randomized run
// checked against an elapsed-edge arithmetic model.
module tb_multi_tick_divider;

   localparam int NCH = 3;
   localparam int DW  = 4;
   localparam int CSW = 2;

   logic           clk_src = 1'b0;
   logic           rst     = 1'b1;
   logic           en      = 1'b0;
   logic           sync_in = 1'b0;
   logic           cfg_we  = 1'b0;
   logic [CSW-1:0] cfg_ch  = '0;
   logic [DW-1:0]  cfg_div = '0;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] clk_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_src = ~clk_src;

   multi_tick_divider #(
      .NUM_CH     (NCH),
      .DIV_WIDTH  (DW),
      .CH_SEL_W   (CSW),
      .DEFAULT_DIV(0)
   ) u_dut (
      .clk_src(clk_src),
      .rst    (rst),
      .en     (en),
`ifdef TICK_DIVIDER_SYNC_EN
      .sync_in(sync_in),
`endif
      .cfg_we (cfg_we),
      .cfg_ch (cfg_ch),
      .cfg_div(cfg_div),
      .tick   (tick),
      .clk_out(clk_out)
   );

   // Reference model: edges counted since the last clear; ticks on multiples of N, clk_out flips per tick.
   int unsigned     m_div [NCH];
   longint unsigned m_el  [NCH];
   logic            m_base[NCH];
   logic            m_tick[NCH];
   logic            m_clk [NCH];

   task automatic model_step();
      logic do_sync;
`ifdef TICK_DIVIDER_SYNC_EN
      do_sync = sync_in;
`else
      do_sync = 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
         logic hit;
         hit = cfg_we && (int'(cfg_ch) == i);
         if (rst) begin
            m_div[i] = 0; m_el[i] = 0; m_base[i] = 1'b0; m_tick[i] = 1'b0;
         end else if (do_sync) begin
            m_el[i] = 0; m_base[i] = 1'b0; m_tick[i] = 1'b0;
            if (hit) m_div[i] = int'(cfg_div);
         end else if (hit) begin
            m_base[i] = m_clk[i]; m_el[i] = 0; m_div[i] = int'(cfg_div); m_tick[i] = 1'b0;
         end else if (!en || m_div[i] == 0) begin
            m_tick[i] = 1'b0;
         end else begin
            m_el[i]++;
            m_tick[i] = (m_el[i] % m_div[i]) == 0;
         end
         if (m_div[i] == 0) m_clk[i] = m_base[i];
         else               m_clk[i] = m_base[i] ^ logic'((m_el[i] / m_div[i]) % 2);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [NCH-1:0] et, ec;
      for (int i = 0; i < NCH; i++) begin
         et[i] = m_tick[i];
         ec[i] = m_clk[i];
      end
      check({name, "_tick"}, 32'(tick), 32'(et));
      check({name, "_clk_out"}, 32'(clk_out), 32'(ec));
   endtask

   // Model sees the pre-edge inputs, then outputs are sampled 1 ns after the edge.
   task automatic step_clk();
      model_step();
      @(posedge clk_src);
      #1;
   endtask

   task automatic write_div(input int ch, input int div, input string name);
      cfg_we  = 1'b1;
      cfg_ch  = CSW'(ch);
      cfg_div = DW'(div);
      step_clk();
      check_model(name);
      cfg_we  = 1'b0;
   endtask

   typedef struct {
      logic           rst;
      logic           en;
      logic           we;
      logic [CSW-1:0] ch;
      logic [DW-1:0]  div;
      logic [NCH-1:0] exp_tick;
      logic [NCH-1:0] exp_clk;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int cnt0, cnt1, cnt2;

      vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd0, 4'd2, 3'b000, 3'b000};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b001, 3'b001};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000, 3'b001};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b001, 3'b000};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd1, 4'd1, 3'b000, 3'b000};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b011, 3'b011};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'b010, 3'b001};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 3'b000, 3'b001};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'd5, 3'b011, 3'b010};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000};

      for (int v = 0; v < 13; v++) begin
         rst = vecs[v].rst; en = vecs[v].en; cfg_we = vecs[v].we;
         cfg_ch = vecs[v].ch; cfg_div = vecs[v].div;
         step_clk();
         check($sformatf("vec%0d_tick", v), 32'(tick), 32'(vecs[v].exp_tick));
         check($sformatf("vec%0d_clk_out", v), 32'(clk_out), 32'(vecs[v].exp_clk));
      end
      cfg_we = 1'b0;

      // Reset defaults: three reset cycles, then twenty idle enabled cycles with every channel disabled.
      rst = 1'b1; en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step_clk();
         check("reset_hold", 32'({tick, clk_out}), 32'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step_clk();
         check("reset_idle", 32'({tick, clk_out}), 32'd0);
         check_model("reset_idle");
      end

      // Basic divide.
      write_div(0, 5, "basic_wr0");
      write_div(1, 1, "basic_wr1");
      write_div(2, 3, "basic_wr2");
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      for (int k = 0; k < 30; k++) begin
         step_clk();
         check_model("basic");
         cnt0 += int'(tick[0]); cnt1 += int'(tick[1]); cnt2 += int'(tick[2]);
      end
      check("basic_ticks_ch0", 32'(cnt0), 32'd6);
      check("basic_ticks_ch1", 32'(cnt1), 32'd30);
      check("basic_ticks_ch2", 32'(cnt2), 32'd10);

      // Enable freeze after two enabled edges.
      write_div(0, 4, "freeze_wr");
      for (int k = 0; k < 2; k++) begin
         step_clk();
         check_model("freeze_pre");
      end
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step_clk();
         check("freeze_tick", 32'(tick), 32'd0);
         check_model("freeze_gap");
      end
      en = 1'b1;
      step_clk();
      check("freeze_resume1", 32'(tick[0]), 32'd0);
      check_model("freeze_resume1");
      step_clk();
      check("freeze_resume2", 32'(tick[0]), 32'd1);
      check_model("freeze_resume2");

      // Rewrite landing on the terminal edge of a divide-by-4.
      write_div(0, 4, "collide_wr4");
      for (int k = 0; k < 3; k++) begin
         step_clk();
         check_model("collide_pre");
      end
      write_div(0, 6, "collide_wr6");
      check("collide_no_tick", 32'(tick[0]), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         step_clk();
         check("collide_tick0", 32'(tick[0]), 32'(k == 6));
         check_model("collide_after");
      end

      // Out-of-range channel write is ignored; divisor 0 disables a running channel.
      write_div(3, 9, "invalid_wr");
      for (int k = 0; k < 5; k++) begin
         step_clk();
         check_model("invalid_after");
      end
      write_div(2, 0, "zero_wr");
      for (int k = 0; k < 10; k++) begin
         step_clk();
         check("zero_tick2", 32'(tick[2]), 32'd0);
         check_model("zero_after");
      end

      // Maximum divisor for a 4-bit counter.
      write_div(0, 15, "max_wr");
      for (int k = 1; k <= 30; k++) begin
         step_clk();
         check("max_tick0", 32'(tick[0]), 32'(k == 15 || k == 30));
         check_model("max_after");
      end

`ifdef TICK_DIVIDER_SYNC_EN
      write_div(1, 3, "sync_wr1");
      for (int k = 0; k < 7; k++) begin
         step_clk();
         check_model("sync_pre");
      end
      sync_in = 1'b1;
      step_clk();
      check("sync_outputs", 32'({tick, clk_out}), 32'd0);
      check_model("sync_pulse");
      sync_in = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step_clk();
         check("sync_tick0", 32'(tick[0]), 32'(k == 15));
         check("sync_tick1", 32'(tick[1]), 32'(k % 3 == 0));
         check_model("sync_after");
      end
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst     = ($urandom_range(0, 199) == 0);
         en      = ($urandom_range(0, 7) != 0);
         cfg_we  = ($urandom_range(0, 7) == 0);
         cfg_ch  = CSW'($urandom_range(0, 3));
         cfg_div = ($urandom_range(0, 9) == 0) ? 4'd15 : DW'($urandom_range(0, 6));
`ifdef TICK_DIVIDER_SYNC_EN
         sync_in = ($urandom_range(0, 63) == 0);
`endif
         step_clk();
         check_model("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
